// File: rtl/cordic_pipe_scheduler.sv
// -----------------------------------------------------------------------------
// cordic_pipe_scheduler
//
// Shares one fixed-latency CORDIC pipeline between two requesters. Each cycle
// in RUN at most one operand is issued, picked round-robin among requesters
// that have an operand and have fewer than MAX_OUT operations in flight. A
// LATENCY-deep {valid, id} tag line runs alongside the CORDIC so each result
// is routed back to the requester that issued it. DRAIN stops issuing and
// waits for the tag line to empty, then the block parks in IDLE.
//
// Parameters
//   LATENCY  CORDIC depth in cycles from issue to result (>= 2)
//   MAX_OUT  maximum in-flight operations per requester (1..15)
//
// Ports
//   clock          single clock, rising edge
//   aclr           asynchronous active-high reset
//   clk_en         global enable; low freezes every register
//   reqN_valid     requester N presents an operand
//   reqN_data      requester N operand (IEEE-754 single)
//   reqN_ready     operand of requester N accepted this cycle
//   drain          stop issuing and empty the pipeline
//   cordic_clk_en  enable for the CORDIC (mirrors clk_en)
//   cordic_dataa   operand to the CORDIC (zero on bubble cycles)
//   cordic_result  result from the CORDIC
//   rspN_valid     rsp_data belongs to requester N
//   rsp_data       result passed through from the CORDIC
//   idle           scheduler is parked in IDLE
//
// Optional build macro CORDIC_SCHED_STATS_EN adds saturating 16-bit counters:
//   issue_cnt0, issue_cnt1  grants per requester
//   bubble_cnt              RUN-state cycles without a grant
// -----------------------------------------------------------------------------
module cordic_pipe_scheduler #(
    parameter int unsigned LATENCY = 32'd16,
    parameter int unsigned MAX_OUT = 32'd8
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [31:0] req0_data,
    input  logic [31:0] req1_data,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic        drain,
    output logic        cordic_clk_en,
    output logic [31:0] cordic_dataa,
    input  logic [31:0] cordic_result,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_data,
    output logic        idle
`ifdef CORDIC_SCHED_STATS_EN
    ,
    output logic [15:0] issue_cnt0,
    output logic [15:0] issue_cnt1,
    output logic [15:0] bubble_cnt
`endif
);

    localparam int unsigned LAST  = LATENCY - 32'd1;
    localparam int unsigned PREV  = LATENCY - 32'd2;
    localparam logic [3:0]  MAX_C = 4'(MAX_OUT);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

    state_t              state_r;
    logic                last_gnt_r;    // id of the requester granted most recently
    logic [LATENCY-1:0]  tag_valid_r;
    logic [LATENCY-1:0]  tag_id_r;
    logic [3:0]          out_cnt0_r;
    logic [3:0]          out_cnt1_r;

    logic                elig0_s;
    logic                elig1_s;
    logic                gnt0_s;
    logic                gnt1_s;
    logic                gnt_any_s;
    logic                rsp0_s;
    logic                rsp1_s;
    logic                pending_s;

    // Up/down step for an outstanding counter; simultaneous inc and dec cancel.
    function automatic logic [3:0] cnt_step(input logic [3:0] cnt,
                                            input logic       inc,
                                            input logic       dec);
        logic [3:0] nxt;
        case ({inc, dec})
            2'b10:   nxt = cnt + 4'd1;
            2'b01:   nxt = cnt - 4'd1;
            default: nxt = cnt;
        endcase
        return nxt;
    endfunction

`ifdef CORDIC_SCHED_STATS_EN
    // Saturating increment for the statistics counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt,
                                              input logic        inc);
        logic [15:0] nxt;
        if (inc && (cnt != 16'hFFFF)) begin
            nxt = cnt + 16'd1;
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction
`endif

    // Eligibility and round-robin grant; nothing is granted while frozen,
    // in reset, or outside RUN.
    always_comb begin
        elig0_s = req0_valid && (out_cnt0_r < MAX_C);
        elig1_s = req1_valid && (out_cnt1_r < MAX_C);
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        if (!aclr && clk_en && (state_r == ST_RUN)) begin
            if (elig0_s && elig1_s) begin
                // Both want the slot: the one not served last time wins.
                if (last_gnt_r) begin
                    gnt0_s = 1'b1;
                end else begin
                    gnt1_s = 1'b1;
                end
            end else if (elig0_s) begin
                gnt0_s = 1'b1;
            end else if (elig1_s) begin
                gnt1_s = 1'b1;
            end else begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Response routing and drain bookkeeping derived from the tag line.
    always_comb begin
        gnt_any_s = gnt0_s | gnt1_s;
        rsp0_s    = clk_en && tag_valid_r[LAST] && !tag_id_r[LAST];
        rsp1_s    = clk_en && tag_valid_r[LAST] &&  tag_id_r[LAST];
        // The last stage retires this cycle, so only the earlier stages decide
        // whether anything is still in flight after the next edge.
        pending_s = |tag_valid_r[PREV:0];
    end

    // Output drive: handshakes, CORDIC operand mux and pass-through signals.
    always_comb begin
        req0_ready    = gnt0_s;
        req1_ready    = gnt1_s;
        cordic_clk_en = clk_en;
        rsp0_valid    = rsp0_s;
        rsp1_valid    = rsp1_s;
        rsp_data      = cordic_result;
        idle          = (state_r == ST_IDLE);
        if (gnt0_s) begin
            cordic_dataa = req0_data;
        end else if (gnt1_s) begin
            cordic_dataa = req1_data;
        end else begin
            cordic_dataa = 32'h0000_0000;
        end
    end

    // Tag shift line tracking which requester owns each CORDIC stage.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            tag_valid_r <= '0;
            tag_id_r    <= '0;
        end else if (clk_en) begin
            tag_valid_r <= {tag_valid_r[PREV:0], gnt_any_s};
            tag_id_r    <= {tag_id_r[PREV:0], gnt1_s};
        end else begin
            tag_valid_r <= tag_valid_r;
            tag_id_r    <= tag_id_r;
        end
    end

    // Per-requester outstanding counters and round-robin pointer.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            out_cnt0_r <= 4'd0;
            out_cnt1_r <= 4'd0;
            last_gnt_r <= 1'b1;     // requester 0 wins the first contest
        end else if (clk_en) begin
            out_cnt0_r <= cnt_step(out_cnt0_r, gnt0_s, rsp0_s);
            out_cnt1_r <= cnt_step(out_cnt1_r, gnt1_s, rsp1_s);
            if (gnt_any_s) begin
                last_gnt_r <= gnt1_s;
            end else begin
                last_gnt_r <= last_gnt_r;
            end
        end else begin
            out_cnt0_r <= out_cnt0_r;
            out_cnt1_r <= out_cnt1_r;
            last_gnt_r <= last_gnt_r;
        end
    end

    // Run / drain / idle state machine.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state_r <= ST_RUN;
        end else if (clk_en) begin
            case (state_r)
                ST_RUN: begin
                    if (drain) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (!drain) begin
                        state_r <= ST_RUN;
                    end else if (!pending_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_IDLE: begin
                    if (!drain) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

`ifdef CORDIC_SCHED_STATS_EN
    logic [15:0] issue_cnt0_r;
    logic [15:0] issue_cnt1_r;
    logic [15:0] bubble_cnt_r;
    logic        bubble_s;

    // A bubble is an enabled RUN cycle in which the slot goes unused.
    always_comb begin
        bubble_s = clk_en && !aclr && (state_r == ST_RUN) && !gnt_any_s;
    end

    // Saturating grant and bubble statistics.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            issue_cnt0_r <= 16'd0;
            issue_cnt1_r <= 16'd0;
            bubble_cnt_r <= 16'd0;
        end else if (clk_en) begin
            issue_cnt0_r <= sat_inc16(issue_cnt0_r, gnt0_s);
            issue_cnt1_r <= sat_inc16(issue_cnt1_r, gnt1_s);
            bubble_cnt_r <= sat_inc16(bubble_cnt_r, bubble_s);
        end else begin
            issue_cnt0_r <= issue_cnt0_r;
            issue_cnt1_r <= issue_cnt1_r;
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    // Statistics outputs come straight from their registers.
    always_comb begin
        issue_cnt0 = issue_cnt0_r;
        issue_cnt1 = issue_cnt1_r;
        bubble_cnt = bubble_cnt_r;
    end
`endif

endmodule

// File: tb/tb_cordic_pipe_scheduler.sv
module tb_cordic_pipe_scheduler;

    localparam int unsigned LAT  = 32'd16;
    localparam int unsigned MAXO = 32'd8;

    logic        clock;
    logic        aclr;
    logic        clk_en;
    logic        req0_valid;
    logic        req1_valid;
    logic [31:0] req0_data;
    logic [31:0] req1_data;
    logic        req0_ready;
    logic        req1_ready;
    logic        drain;
    logic        cordic_clk_en;
    logic [31:0] cordic_dataa;
    logic [31:0] cordic_result;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [31:0] rsp_data;
    logic        idle;
`ifdef CORDIC_SCHED_STATS_EN
    logic [15:0] issue_cnt0;
    logic [15:0] issue_cnt1;
    logic [15:0] bubble_cnt;
`endif

    cordic_pipe_scheduler #(.LATENCY(LAT), .MAX_OUT(MAXO)) dut (
        .clock         (clock),
        .aclr          (aclr),
        .clk_en        (clk_en),
        .req0_valid    (req0_valid),
        .req1_valid    (req1_valid),
        .req0_data     (req0_data),
        .req1_data     (req1_data),
        .req0_ready    (req0_ready),
        .req1_ready    (req1_ready),
        .drain         (drain),
        .cordic_clk_en (cordic_clk_en),
        .cordic_dataa  (cordic_dataa),
        .cordic_result (cordic_result),
        .rsp0_valid    (rsp0_valid),
        .rsp1_valid    (rsp1_valid),
        .rsp_data      (rsp_data),
        .idle          (idle)
`ifdef CORDIC_SCHED_STATS_EN
        ,
        .issue_cnt0    (issue_cnt0),
        .issue_cnt1    (issue_cnt1),
        .bubble_cnt    (bubble_cnt)
`endif
    );

    // CORDIC stub: identity function delayed by LAT enabled cycles.
    logic [31:0] stub_pipe [LAT];
    always @(posedge clock) begin
        if (cordic_clk_en) begin
            stub_pipe[0] <= cordic_dataa;
            for (int i = 1; i < int'(LAT); i++) stub_pipe[i] <= stub_pipe[i-1];
        end
    end
    assign cordic_result = stub_pipe[LAT-1];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic [31:0] en;
        logic [31:0] rc;
    } sb_t;
    sb_t sb_q[$];
    logic gnt_log[$];

    logic [31:0] cyc    = 32'd0;
    logic [31:0] en_cyc = 32'd0;
    int g0 = 0, g1 = 0, r0 = 0, r1 = 0;
    logic [31:0] last_real_lat = 32'd0;
    logic        idle_at_rsp   = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Cycle counters: all cycles and clock-enabled cycles.
    always @(posedge clock) begin
        cyc <= cyc + 32'd1;
        if (clk_en) en_cyc <= en_cyc + 32'd1;
    end

    // Scoreboard: push on each transfer, pop and compare on each response.
    always @(negedge clock) begin
        if (!aclr) begin
            if (rsp0_valid || rsp1_valid) begin
                if (sb_q.size() == 0) begin
                    check_val("rsp_spurious", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    check_val("rsp_id", 32'(rsp1_valid), 32'(e.id));
                    check_val("rsp_data", rsp_data, e.data);
                    check_val("rsp_latency", en_cyc - e.en, LAT);
                    last_real_lat = cyc - e.rc;
                    idle_at_rsp   = idle;
                    if (rsp1_valid) r1++; else r0++;
                end
            end
            if (req0_valid && req0_ready) begin
                sb_q.push_back({1'b0, req0_data, en_cyc, cyc});
                gnt_log.push_back(1'b0);
                g0++;
            end
            if (req1_valid && req1_ready) begin
                sb_q.push_back({1'b1, req1_data, en_cyc, cyc});
                gnt_log.push_back(1'b1);
                g1++;
            end
            if (req0_ready && req1_ready) check_val("dual_grant", 32'd1, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check_val("drain_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic new_data();
        req0_data = 32'hA000_0000 | 32'(g0);
        req1_data = 32'hB000_0000 | 32'(g1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, gb, rb0, rb1, snap;
        logic snapped;
        aclr = 1'b1; clk_en = 1'b1; drain = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_data = 32'h1234_5678; req1_data = 32'h0;
        #3;
        check_val("rst_ready0", 32'(req0_ready), 32'd0);
        check_val("rst_idle", 32'(idle), 32'd0);
        check_val("rst_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        repeat (3) tick();
        aclr = 1'b0; req0_valid = 1'b0;
        tick();

        // Single operand from requester 0.
        req0_valid = 1'b1; req0_data = 32'h3F80_0000;
        #1 check_val("t1_ready0", 32'(req0_ready), 32'd1);
        check_val("t1_dataa", cordic_dataa, 32'h3F80_0000);
        tick();
        req0_valid = 1'b0;
        #1 check_val("t1_bubble", cordic_dataa, 32'h0);
        wait_drain(40);
        check_val("t1_rsp0_cnt", 32'(r0), 32'd1);

        // Both requesters contend for 8 cycles after a fresh reset.
        tick(); aclr = 1'b1; tick(); aclr = 1'b0;
        base = gnt_log.size(); rb0 = r0; rb1 = r1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (8) begin new_data(); tick(); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check_val("t2_grants", 32'(gnt_log.size() - base), 32'd8);
        for (int i = 0; i < 8; i++)
            if (base + i < gnt_log.size())
                check_val("t2_rr_order", 32'(gnt_log[base+i]), 32'(i % 2));
        wait_drain(40);
        check_val("t2_rsp0", 32'(r0 - rb0), 32'd4);
        check_val("t2_rsp1", 32'(r1 - rb1), 32'd4);

        // Requester 1 alone: stalls at MAX_OUT until its first response.
        gb = g1; rb1 = r1; snap = -1; snapped = 1'b0;
        req1_valid = 1'b1;
        repeat (30) begin
            if (!snapped && r1 != rb1) begin snap = g1 - gb; snapped = 1'b1; end
            new_data(); tick();
        end
        req1_valid = 1'b0;
        check_val("t3_grants_before_rsp", 32'(snap), 32'd8);
        check_val("t3_total_grants", 32'(g1 - gb), 32'd16);
        wait_drain(40);

        // Drain after three issues.
        gb = g0;
        req0_valid = 1'b1;
        repeat (3) begin new_data(); tick(); end
        req0_valid = 1'b0; drain = 1'b1;
        tick();
        req0_valid = 1'b1;
        #1 check_val("t4_no_ready", 32'(req0_ready), 32'd0);
        wait_drain(40);
        @(negedge clock);
        check_val("t4_idle_at_rsp", 32'(idle_at_rsp), 32'd0);
        check_val("t4_idle", 32'(idle), 32'd1);
        check_val("t4_issues", 32'(g0 - gb), 32'd3);
        req0_valid = 1'b0;
        tick();
        drain = 1'b0;
        #1 check_val("t4_still_idle", 32'(idle), 32'd1);
        tick();
        check_val("t4_run", 32'(idle), 32'd0);

        // Freeze for 5 cycles mid-stream.
        req0_valid = 1'b1;
        repeat (4) begin new_data(); tick(); end
        req0_valid = 1'b0;
        repeat (3) tick();
        clk_en = 1'b0; req0_valid = 1'b1;
        #1 check_val("t5_ready_frozen", 32'(req0_ready), 32'd0);
        check_val("t5_cordic_en", 32'(cordic_clk_en), 32'd0);
        repeat (5) tick();
        clk_en = 1'b1; req0_valid = 1'b0;
        wait_drain(40);
        check_val("t5_real_latency", last_real_lat, LAT + 32'd5);

        // Reset with four operations in flight.
        req0_valid = 1'b1;
        repeat (4) begin new_data(); tick(); end
        req0_valid = 1'b0;
        repeat (3) tick();
        aclr = 1'b1;
        sb_q.delete();
        req0_valid = 1'b1;
        #1 check_val("t6_ready_in_rst", 32'(req0_ready), 32'd0);
        tick(); tick();
        aclr = 1'b0;
        gb = g0; rb0 = r0;
        repeat (14) begin new_data(); tick(); end
        req0_valid = 1'b0;
        check_val("t6_cnt_cleared", 32'(g0 - gb), 32'd8);
        wait_drain(40);
        repeat (20) tick();
        check_val("t6_rsp_count", 32'(r0 - rb0), 32'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_pipe_scheduler.md
CORDIC_PIPE_SCHEDULER -- requirements
Module: cordic_pipe_scheduler

Interface
REQ-001 SHALL have parameter LATENCY, default 16, meaning the CORDIC pipeline depth in cycles from issue to result.
REQ-002 SHALL have parameter MAX_OUT, default 8, meaning the maximum in-flight operations per requester (1..15).
REQ-003 SHALL have port clock  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port aclr  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port clk_en  in  1  global enable; low freezes all state.
REQ-006 SHALL have ports req0_valid, req1_valid  in  1 each  the requester has an operand.
REQ-007 SHALL have ports req0_data, req1_data  in  32 each  IEEE-754 single operand.
REQ-008 SHALL have ports req0_ready, req1_ready  out  1 each  the operand is accepted this cycle.
REQ-009 SHALL have port drain  in  1  request to stop issuing and empty the pipeline.
REQ-010 SHALL have port cordic_clk_en  out  1  drives the CORDIC clk_en; equals clk_en.
REQ-011 SHALL have port cordic_dataa  out  32  operand to the CORDIC.
REQ-012 SHALL have port cordic_result  in  32  CORDIC result.
REQ-013 SHALL have ports rsp0_valid, rsp1_valid  out  1 each  result belongs to that requester.
REQ-014 SHALL have port rsp_data  out  32  equals cordic_result.
REQ-015 SHALL have port idle  out  1  high in state IDLE.

Function
REQ-016 SHALL implement states RUN, DRAIN and IDLE.
REQ-017 SHALL move RUN->DRAIN on drain=1, DRAIN->IDLE when the tag line holds no valid entry, and IDLE->RUN on drain=0; DRAIN with drain=0 returns to RUN.
REQ-018 SHALL, in RUN, grant at most one requester per cycle; a requester is eligible when reqN_valid=1 and its outstanding count is below MAX_OUT.
REQ-019 SHALL use round-robin arbitration: when both are eligible, grant the requester not granted most recently; the pointer updates only on a grant.
REQ-020 SHALL assert reqN_ready combinationally in the grant cycle; a transfer occurs when reqN_valid and reqN_ready are both 1.
REQ-021 SHALL drive cordic_dataa with the granted data, else 32'h0 (bubble).
REQ-022 SHALL keep a LATENCY-deep tag shift line of {valid, id}, shifted when clk_en=1, with a grant entering at stage 0.
REQ-023 SHALL assert rspN_valid when the last tag stage is valid with id=N, so a result appears exactly LATENCY cycles after its grant.
REQ-024 SHALL increment a requester's 4-bit outstanding counter on grant and decrement it on response; both in the same cycle leave it unchanged.
REQ-025 SHALL, with clk_en=0, hold all state, drive reqN_ready=0 and rspN_valid=0, and present the CORDIC with a frozen pipeline.
REQ-026 SHALL grant nothing in DRAIN or IDLE while still retiring in-flight results.

Reset
REQ-027 SHALL, on aclr=1, immediately clear all tag stages and counters, set the state to RUN and the pointer so requester 0 wins first, and drive ready, rsp_valid and idle to 0.
REQ-028 SHALL discard results of operations in flight at reset; no rsp_valid fires for them.

Configuration
REQ-029 SHALL, with CORDIC_SCHED_STATS_EN defined, add outputs issue_cnt0, issue_cnt1 and bubble_cnt (16 bits each, saturating at 16'hFFFF, cleared by aclr) counting grants per requester and RUN-state bubbles.
REQ-030 SHALL, without CORDIC_SCHED_STATS_EN, omit those ports and their logic entirely.

Verification
REQ-031 SHALL verify: only req0 valid, with data 0x3F800000 at cycle t -> rsp0_valid at t+16 with rsp_data from the CORDIC stub matching the operand.
REQ-032 SHALL verify: both requesters continuously valid for 8 cycles -> grants alternate 0,1,0,1…, with 4 responses each and IDs in issue order.
REQ-033 SHALL verify: req1 continuously valid with no responses -> exactly 8 grants, then req1_ready stays 0 until the first rsp1_valid.
REQ-034 SHALL verify: drain=1 after 3 issues -> no new grants, idle=1 one cycle after the third response, and idle=0 after drain=0.
REQ-035 SHALL verify: clk_en=0 for 5 cycles mid-stream -> response timing shifts by exactly 5 cycles.
REQ-036 SHALL verify: aclr pulsed with 4 operations in flight -> no rsp_valid afterward, and counters read 0.
